// File: rtl/graycode_pkg.sv
// Shared constants and slice-geometry helpers for the pipelined Gray-code converter.
package graycode_pkg;

   localparam logic MODE_BIN2GRAY = 1'b0;
   localparam logic MODE_GRAY2BIN = 1'b1;

   // Bits resolved per stage: ceil(width / stages).
   function automatic int slice_size(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   // Low bit of slice k (slices run from the MSB downward), clamped at 0.
   function automatic int slice_lo(input int k, input int width, input int stages);
      int lo;
      lo = width - (k + 1) * slice_size(width, stages);
      return (lo < 0) ? 0 : lo;
   endfunction

   // High bit of slice k; negative when the slice is empty.
   function automatic int slice_hi(input int k, input int width, input int stages);
      return width - 1 - k * slice_size(width, stages);
   endfunction

endpackage

// File: rtl/graycode_pipe_stage.sv
// One pipeline stage: resolves one slice of a Gray->binary word (or the whole
// binary->Gray word in stage 0) and registers valid, mode, word and carry.
module graycode_pipe_stage
   import graycode_pkg::*;
#(
   parameter int data_width = 16,
   parameter int stages     = 4,
   parameter int slice_idx  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic                  mode_i,
   input  logic [data_width-1:0] data_i,
   input  logic                  carry_i,
   input  logic                  en_next_i,
   output logic                  en_o,
   output logic                  valid_o,
   output logic                  mode_o,
   output logic [data_width-1:0] data_o,
   output logic                  carry_o
);

   localparam int HI = slice_hi(slice_idx, data_width, stages);
   localparam int LO = slice_lo(slice_idx, data_width, stages);

   logic                  valid_q;
   logic                  mode_q;
   logic [data_width-1:0] data_q;
   logic                  carry_q;

   logic [data_width-1:0] g2b_w;
   logic [data_width-1:0] b2g_w;
   logic [data_width-1:0] data_d;
   logic                  carry_d;

   // Each slice bit is the carry XORed with every Gray bit from the slice top
   // down to it; bits outside the slice pass through untouched.
   for (genvar gi = 0; gi < data_width; gi++) begin : g_bit
      if (gi <= HI && gi >= LO) begin : g_in_slice
         assign g2b_w[gi] = carry_i ^ (^data_i[HI:gi]);
      end else begin : g_pass
         assign g2b_w[gi] = data_i[gi];
      end
   end

   // Binary->Gray is shallow, so the whole word is converted in stage 0.
   if (slice_idx == 0) begin : g_b2g
      assign b2g_w = data_i ^ (data_i >> 1);
   end else begin : g_b2g_pass
      assign b2g_w = data_i;
   end

   // The carry forwarded downstream is the lowest resolved bit of this slice.
   if (HI >= LO) begin : g_carry
      assign carry_d = g2b_w[LO];
   end else begin : g_carry_pass
      assign carry_d = carry_i;
   end

   assign data_d  = (mode_i == MODE_GRAY2BIN) ? g2b_w : b2g_w;
   assign en_o    = !valid_q || en_next_i;

   // Stage register: loads whenever the stage is empty or its content moves on.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         mode_q  <= MODE_BIN2GRAY;
         data_q  <= '0;
         carry_q <= 1'b0;
      end else if (en_o) begin
         valid_q <= valid_i;
         mode_q  <= mode_i;
         data_q  <= data_d;
         carry_q <= carry_d;
      end
   end

   assign valid_o = valid_q;
   assign mode_o  = mode_q;
   assign data_o  = data_q;
   assign carry_o = carry_q;

endmodule

// File: rtl/graycode_pipe_converter.sv
// Pipelined binary/Gray converter with valid/ready on both sides and a
// per-beat mode; the stage chain and enable chain are stitched together here.
module graycode_pipe_converter
   import graycode_pkg::*;
#(
   parameter int data_width = 16,
   parameter int stages     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_mode,
   input  logic [data_width-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_mode,
   output logic [data_width-1:0] out_data
);

   if (data_width < 1 || stages < 1 || stages > data_width) begin : g_bad_params
      $error("graycode_pipe_converter: illegal data_width/stages combination");
   end

   for (genvar gi = 0; gi < stages; gi++) begin : g_stage
      logic                  valid_in;
      logic                  mode_in;
      logic [data_width-1:0] data_in;
      logic                  carry_in;
      logic                  en_next;
      logic                  en;
      logic                  valid;
      logic                  mode;
      logic [data_width-1:0] data;
      logic                  carry;

      if (gi == 0) begin : g_head
         assign valid_in = in_valid;
         assign mode_in  = in_mode;
         assign data_in  = in_data;
         assign carry_in = 1'b0;
      end else begin : g_link
         assign valid_in = g_stage[gi-1].valid;
         assign mode_in  = g_stage[gi-1].mode;
         assign data_in  = g_stage[gi-1].data;
         assign carry_in = g_stage[gi-1].carry;
      end

      // Enable ripples back from the consumer: a stage may load if the next one can.
      if (gi == stages - 1) begin : g_tail
         logic carry_unused;
         assign en_next      = out_ready;
         assign carry_unused = carry;
      end else begin : g_mid
         assign en_next = g_stage[gi+1].en;
      end

      graycode_pipe_stage #(
         .data_width (data_width),
         .stages     (stages),
         .slice_idx  (gi)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .valid_i   (valid_in),
         .mode_i    (mode_in),
         .data_i    (data_in),
         .carry_i   (carry_in),
         .en_next_i (en_next),
         .en_o      (en),
         .valid_o   (valid),
         .mode_o    (mode),
         .data_o    (data),
         .carry_o   (carry)
      );
   end

   assign in_ready  = g_stage[0].en && !rst;
   assign out_valid = g_stage[stages-1].valid;
   assign out_mode  = g_stage[stages-1].mode;
   assign out_data  = g_stage[stages-1].data;

endmodule
